// File: rtl/game_flow_ctrl_pkg.sv
// Shared game-level types and constants: FSM state encoding, keycodes, elite count.
// Also imported by the overworld and battle blocks.
package game_pkg;

  localparam int NUM_BATTLES = 5;
  localparam int CUR_W       = 3;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [2:0] {
    ST_ROAM      = 3'd0,
    ST_TRANS     = 3'd1,
    ST_BATTLE    = 3'd2,
    ST_WIN_HOLD  = 3'd3,
    ST_LOSE_HOLD = 3'd4,
    ST_CHAMP     = 3'd5
  } game_state_t;

  function automatic logic is_last_elite(input logic [CUR_W-1:0] idx);
    return idx == CUR_W'(NUM_BATTLES - 1);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Handshake between the game sequencer (slave) and the overworld/battle blocks (master).
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic             start_battle;
  logic             battle_won;
  logic             battle_lost;
  logic             is_roam;
  logic             is_battle;
  logic [CUR_W-1:0] cur_battle;

  modport master (
    output start_battle, battle_won, battle_lost,
    input  is_roam, is_battle, cur_battle
  );

  modport slave (
    input  start_battle, battle_won, battle_lost,
    output is_roam, is_battle, cur_battle
  );

endinterface

// File: rtl/game_flow_ctrl_frame_edge_det.sv
// Registered rising-edge pulse of the frame clock, one Clk wide, one Clk late.
module frame_edge_det (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic fedge
);

  logic frame_clk_delayed_r;
  logic fedge_r;

  // Delay flop and edge pulse register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_delayed_r <= 1'b0;
      fedge_r             <= 1'b0;
    end else begin
      frame_clk_delayed_r <= frame_clk;
      fedge_r             <= frame_clk & ~frame_clk_delayed_r;
    end
  end

  assign fedge = fedge_r;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: roam -> flash transition -> battle -> result hold -> next elite,
// with a champion screen after the last elite.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter logic [7:0] TRANS_FRAMES  = 8'd30,
  parameter logic [7:0] RESULT_FRAMES = 8'd60,
  parameter int         FLASH_SHIFT   = 2,
  parameter logic [7:0] ENTER         = KEY_ENTER
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_clk,
  input  logic [7:0]           keycode,
  game_flow_ctrl_if.slave      flow,
  output logic                 flash,
  output logic                 champion,
  output logic [2:0]           state_dbg
);

  game_state_t      state_r, state_nxt_s;
  logic [CUR_W-1:0] cur_battle_r, cur_battle_nxt_s;
  logic             armed_r, armed_nxt_s;
  logic [7:0]       frame_cnt_r, frame_cnt_nxt_s;
  logic             champion_r, champion_nxt_s;
  logic             flash_r, flash_nxt_s;
  logic             fedge_s;
  logic [7:0]       frame_inc_s;
  logic             trans_last_s;
  logic             hold_last_s;

  frame_edge_det u_fedge (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .fedge     (fedge_s)
  );

  assign frame_inc_s  = frame_cnt_r + 8'd1;
  assign trans_last_s = (frame_cnt_r == TRANS_FRAMES - 8'd1);
  assign hold_last_s  = (frame_cnt_r == RESULT_FRAMES - 8'd1);

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= ST_ROAM;
      cur_battle_r <= '0;
      armed_r      <= 1'b0;
      frame_cnt_r  <= 8'd0;
      champion_r   <= 1'b0;
      flash_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cur_battle_r <= cur_battle_nxt_s;
      armed_r      <= armed_nxt_s;
      frame_cnt_r  <= frame_cnt_nxt_s;
      champion_r   <= champion_nxt_s;
      flash_r      <= flash_nxt_s;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_nxt_s      = state_r;
    cur_battle_nxt_s = cur_battle_r;
    armed_nxt_s      = armed_r;
    frame_cnt_nxt_s  = frame_cnt_r;
    champion_nxt_s   = champion_r;
    flash_nxt_s      = 1'b0;

    case (state_r)
      ST_ROAM: begin
        // Arming needs a cycle without ENTER so a held key cannot retrigger a battle.
        if (keycode != ENTER) begin
          armed_nxt_s = 1'b1;
        end else begin
          armed_nxt_s = armed_r;
        end
        if (flow.start_battle && armed_r) begin
          state_nxt_s     = ST_TRANS;
          frame_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = ST_ROAM;
        end
      end

      ST_TRANS: begin
        if (fedge_s && trans_last_s) begin
          state_nxt_s     = ST_BATTLE;
          frame_cnt_nxt_s = 8'd0;
          flash_nxt_s     = 1'b0;
        end else if (fedge_s) begin
          frame_cnt_nxt_s = frame_inc_s;
          flash_nxt_s     = frame_inc_s[FLASH_SHIFT];
        end else begin
          flash_nxt_s = frame_cnt_r[FLASH_SHIFT];
        end
      end

      ST_BATTLE: begin
        if (flow.battle_won) begin
          state_nxt_s     = ST_WIN_HOLD;
          frame_cnt_nxt_s = 8'd0;
        end else if (flow.battle_lost) begin
          state_nxt_s     = ST_LOSE_HOLD;
          frame_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = ST_BATTLE;
        end
      end

      ST_WIN_HOLD: begin
        if (fedge_s && hold_last_s) begin
          frame_cnt_nxt_s = 8'd0;
          if (is_last_elite(cur_battle_r)) begin
            state_nxt_s    = ST_CHAMP;
            champion_nxt_s = 1'b1;
          end else begin
            state_nxt_s      = ST_ROAM;
            cur_battle_nxt_s = cur_battle_r + CUR_W'(1);
            armed_nxt_s      = 1'b0;
          end
        end else if (fedge_s) begin
          frame_cnt_nxt_s = frame_inc_s;
        end else begin
          frame_cnt_nxt_s = frame_cnt_r;
        end
      end

      ST_LOSE_HOLD: begin
        if (fedge_s && hold_last_s) begin
          frame_cnt_nxt_s  = 8'd0;
          state_nxt_s      = ST_ROAM;
          cur_battle_nxt_s = '0;
          armed_nxt_s      = 1'b0;
        end else if (fedge_s) begin
          frame_cnt_nxt_s = frame_inc_s;
        end else begin
          frame_cnt_nxt_s = frame_cnt_r;
        end
      end

      ST_CHAMP: begin
        champion_nxt_s = 1'b1;
        if (keycode == ENTER) begin
          state_nxt_s      = ST_ROAM;
          cur_battle_nxt_s = '0;
          champion_nxt_s   = 1'b0;
          armed_nxt_s      = 1'b0;
        end else begin
          state_nxt_s = ST_CHAMP;
        end
      end

      default: begin
        state_nxt_s      = ST_ROAM;
        cur_battle_nxt_s = '0;
        armed_nxt_s      = 1'b0;
        frame_cnt_nxt_s  = 8'd0;
        champion_nxt_s   = 1'b0;
      end
    endcase
  end

  assign flow.is_roam    = (state_r == ST_ROAM);
  assign flow.is_battle  = (state_r == ST_BATTLE);
  assign flow.cur_battle = cur_battle_r;
  assign flash           = flash_r;
  assign champion        = champion_r;
  assign state_dbg       = state_r;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer and the responder to the overworld block's battle request.
- Consumes start_battle from the overworld and win/lose results from the battle engine.
- Drives is_roam, is_battle and cur_battle back to both sides.
- Sequences roam -> flash transition -> battle -> result hold -> next elite or restart, and latches champion status after the last elite.

Parameters:
NUM_BATTLES, 5, number of elite battles; cur_battle ranges 0..NUM_BATTLES-1
TRANS_FRAMES, 8'd30, frame edges spent in the flash transition before battle
RESULT_FRAMES, 8'd60, frame edges the win/lose result is held before leaving
FLASH_SHIFT, 2, frame-counter bit that drives flash (toggles every 4 frames)
ENTER, 8'h28, keycode that restarts from the champion screen

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_clk  in  1  vertical-sync-rate frame clock, sampled in Clk domain
start_battle  in  1  level battle request from the overworld
battle_won  in  1  one-Clk pulse from the battle engine: player won
battle_lost  in  1  one-Clk pulse from the battle engine: player lost
keycode  in  8  current HID keycode, 0 when no key is pressed
is_roam  out  1  overworld active
is_battle  out  1  battle engine active
cur_battle  out  3  index of the current/next elite
flash  out  1  transition overlay enable
champion  out  1  all elites beaten
state_dbg  out  3  encoded FSM state for the hex display

Behaviour:
- Reset is asynchronous, active-low.
- Reset values: state=ROAM, cur_battle=0, armed=0, frame_cnt=0, champion=0, flash=0.
- Reset values of decoded outputs: is_roam=1, is_battle=0.
- Frame edge detection:
  - frame_clk_delayed <= frame_clk.
  - fedge <= frame_clk & ~frame_clk_delayed.
  - fedge is one registered pulse per rising edge and lags by one Clk.
- All outputs are registered or decoded directly from state registers; none depends combinationally on inputs.
- state_dbg encoding: ROAM=0, TRANS=1, BATTLE=2, WIN_HOLD=3, LOSE_HOLD=4, CHAMP=5.
- ROAM (is_roam=1):
  - armed is cleared on entry.
  - armed sets on any cycle with keycode!=ENTER.
  - start_battle && armed -> TRANS, with frame_cnt=0.
  - start_battle while !armed is ignored. This blocks a held ENTER from retriggering a battle on return.
- TRANS (is_roam=0, is_battle=0):
  - frame_cnt increments on each fedge.
  - flash = frame_cnt[FLASH_SHIFT].
  - Exit when fedge && frame_cnt==TRANS_FRAMES-1 -> BATTLE, with frame_cnt=0 and flash=0.
  - battle_won and battle_lost are ignored in this state.
- BATTLE (is_battle=1):
  - battle_won -> WIN_HOLD.
  - battle_lost -> LOSE_HOLD.
  - Both asserted in the same cycle: won has priority.
  - start_battle is ignored.
- WIN_HOLD / LOSE_HOLD (both active flags 0):
  - Count RESULT_FRAMES fedges.
  - WIN_HOLD, cur_battle==NUM_BATTLES-1 -> CHAMP, champion=1.
  - WIN_HOLD, any other cur_battle -> cur_battle+1, then ROAM.
  - LOSE_HOLD -> cur_battle=0, then ROAM. The elite run restarts.
- CHAMP:
  - is_roam=0, champion held at 1.
  - keycode==ENTER -> ROAM, with cur_battle=0 and champion=0. armed is then 0, so the same held ENTER cannot start a battle.
- cur_battle changes only at the WIN_HOLD/LOSE_HOLD/CHAMP exits and never exceeds NUM_BATTLES-1.
- frame_cnt is 8 bits and saturates-safe because every exit compares for equality. TRANS_FRAMES and RESULT_FRAMES must each be >=1.
- Reset_n asserted mid-operation: immediate return to the reset values above, from any state.

Decomposition:
- Package game_pkg holds:
  - the state enum typedef game_state_t (3-bit) with the encoding above;
  - keycode constants W/A/S/D/ENTER, shared with the overworld;
  - NUM_BATTLES.
- One sub-module, frame_edge_det:
  - contains the frame_clk delay flop and the registered rising-edge pulse;
  - is reusable by the overworld and battle blocks.

Test Plan:
- Reset then idle: Reset_n=0 for 3 Clk, release -> is_roam=1, is_battle=0, cur_battle=0, state_dbg=0, flash=0.
- Battle entry: keycode=0 for 1 cycle, then start_battle=1 -> state_dbg=1 next Clk. After 30 frame edges is_battle=1. flash toggles every 4 frames, first high after frame edge 4.
- Held-ENTER guard: win battle 0 while keycode=8'h28 held and start_battle=1 throughout. Return to ROAM with cur_battle=1 and no TRANS. Drop keycode to 0 for 1 Clk -> TRANS next Clk.
- Simultaneous result: in BATTLE pulse battle_won=1 and battle_lost=1 together -> WIN_HOLD (state_dbg=3). After 60 frame edges cur_battle increments by 1.
- Loss restart: reach cur_battle=3, lose -> LOSE_HOLD. After 60 frame edges ROAM with cur_battle=0.
- Championship and mid-op reset:
  - Win battles 0..4 -> CHAMP, champion=1, cur_battle=4.
  - keycode=8'h28 -> ROAM, cur_battle=0, champion=0.
  - Separately, assert Reset_n=0 during TRANS -> is_roam=1 and flash=0 immediately, without waiting for a Clk edge.
